// File: rtl/life_pkg.sv
// Shared Life display types: screen geometry, colours, plotter states.
// Imported by the plotter top and its event FIFO.
package life_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_ALIVE = 3'b111;
  localparam logic [COLOUR_W-1:0] COLOUR_DEAD  = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAW
  } plot_state_e;

  typedef struct packed {
    logic [7:0]          col;
    logic [7:0]          row;
    logic [COLOUR_W-1:0] colour;
  } cell_evt_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of cell events {col,row,colour}.
// Ports: push/push_data in, pop in, head out, full/empty/count out.
module plot_fifo
  import life_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  cell_evt_t push_data,
  input  logic      pop,
  output cell_evt_t head,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  localparam int CW = AW + 1;

  cell_evt_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/cell_block_plotter.sv
// Draws cell-change events as CELL_W x CELL_W blocks, or clears the screen.
// Ports: in_* event handshake, clear_req, busy, out_x/out_y/out_colour/plot.
module cell_block_plotter
  import life_pkg::*;
#(
  parameter int CELL_W     = 4,
  parameter int GRID_COLS  = 40,
  parameter int GRID_ROWS  = 30,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_col,
  input  logic [7:0] in_row,
  input  logic [2:0] in_colour,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_colour,
  output logic       plot
);

  localparam int SH = $clog2(CELL_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] D_LAST = 3'(CELL_W - 1);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0] COLS_L = 8'(GRID_COLS);
  localparam logic [7:0] ROWS_L = 8'(GRID_ROWS);

  plot_state_e state_q, state_d;
  logic [8:0]  base_x_q, base_x_d;
  logic [8:0]  base_y_q, base_y_d;
  logic [2:0]  colour_q, colour_d;
  logic [2:0]  dx_q, dx_d, dy_q, dy_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic        pend_q, pend_d;
  logic        plot_q, plot_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  oc_q, oc_d;
  logic        busy_q, busy_d;

  logic          push, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, cnt_nx;
  cell_evt_t     push_data, head;
  logic [8:0]    bx, by;
  logic [2:0]    nx, ny;
  logic [7:0]    ncx;
  logic [6:0]    ncy;

  assign push_data = '{col: in_col, row: in_row, colour: in_colour};
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    colour_d = colour_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    pend_d   = pend_q | clear_req;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    oc_d     = oc_q;
    pop      = 1'b0;
    bx       = {1'b0, head.col} << SH;
    by       = {1'b0, head.row} << SH;
    nx       = (dx_q == D_LAST) ? 3'd0 : dx_q + 3'd1;
    ny       = (dx_q == D_LAST) ? dy_q + 3'd1 : dy_q;
    ncx      = (cx_q == X_LAST) ? 8'd0 : cx_q + 8'd1;
    ncy      = (cx_q == X_LAST) ? cy_q + 7'd1 : cy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // Pixel (0,0) goes out on the entry edge.
          state_d = ST_CLEAR;
          pend_d  = clear_req;
          cx_d    = '0;
          cy_d    = '0;
          plot_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
          oc_d    = COLOUR_DEAD;
        end else if (!fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pop      = 1'b1;
        base_x_d = bx;
        base_y_d = by;
        colour_d = head.colour;
        dx_d     = '0;
        dy_d     = '0;
        if (head.col >= COLS_L || head.row >= ROWS_L) begin
          state_d = ST_IDLE;
        end else begin
          // First block pixel leaves with the pop.
          plot_d  = 1'b1;
          x_d     = bx[7:0];
          y_d     = by[6:0];
          oc_d    = head.colour;
          state_d = (CELL_W == 1) ? ST_IDLE : ST_DRAW;
        end
      end
      ST_DRAW: begin
        dx_d   = nx;
        dy_d   = ny;
        plot_d = 1'b1;
        x_d    = 8'(base_x_q + {6'd0, nx});
        y_d    = 7'(base_y_q + {6'd0, ny});
        oc_d   = colour_q;
        if (nx == D_LAST && ny == D_LAST) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        cx_d   = ncx;
        cy_d   = ncy;
        plot_d = 1'b1;
        x_d    = ncx;
        y_d    = ncy;
        oc_d   = COLOUR_DEAD;
        if (ncx == X_LAST && ncy == Y_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_nx = fifo_count + CW'(push) - CW'(pop);
    busy_d = (state_d != ST_IDLE) || (cnt_nx != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      colour_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      pend_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      oc_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      colour_q <= colour_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      pend_q   <= pend_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      oc_q     <= oc_d;
      busy_q   <= busy_d;
    end
  end

  assign plot       = plot_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_colour = oc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cell_block_plotter.sv
// Directed bench for cell_block_plotter.
// Logs every plotted pixel and checks it against hand-built expectations.
module tb_cell_block_plotter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_col;
  logic [7:0] in_row;
  logic [2:0] in_colour;
  logic       clear_req;
  logic       busy;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       plot;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t pq[$];
  int   checks = 0;
  int   failures = 0;

  cell_block_plotter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_col     (in_col),
    .in_row     (in_row),
    .in_colour  (in_colour),
    .clear_req  (clear_req),
    .busy       (busy),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (plot === 1'b1) pq.push_back('{x: out_x, y: out_y, c: out_colour});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t mk(input int x, input int y, input int c);
    pix_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.c = 3'(c);
    return p;
  endfunction

  int ec [9] = '{0, 1, 10, 20, 30, 39, 7, 38, 39};
  int er [9] = '{0, 0, 5, 10, 15, 20, 29, 29, 29};

  initial begin
    int nb, nc, ns, k, bad, idx, exc;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_col    = '0;
    in_row    = '0;
    in_colour = '0;
    clear_req = 1'b0;
    repeat (3) tick();

    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_x", 32'(out_x), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_colour", 32'(out_colour), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Single cell (2,3) alive: x 8..11, y 12..15.
    in_col = 8'd2; in_row = 8'd3; in_colour = 3'b111; in_valid = 1'b1;
    chk("c1_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("c1_plot_t0", 32'(plot), 32'd0);
    chk("c1_busy_t0", 32'(busy), 32'd1);
    tick();
    chk("c1_plot_t1", 32'(plot), 32'd0);
    tick();
    for (int p = 0; p < 16; p++) begin
      chk("c1_px", {13'd0, plot, out_x, out_y, out_colour},
          {13'd1, 8'(8 + p % 4), 7'(12 + p / 4), 3'b111});
      if (p < 15) tick();
    end
    tick();
    chk("c1_plot_end", 32'(plot), 32'd0);
    chk("c1_busy_end", 32'(busy), 32'd0);

    // Out-of-range column is swallowed without plots.
    nb = pq.size();
    in_col = 8'd40; in_row = 8'd0; in_colour = 3'b111; in_valid = 1'b1;
    chk("oob_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("oob_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("oob_plots", 32'(pq.size() - nb), 32'd0);

    // Clear requested mid-block; block finishes first.
    nb = pq.size();
    in_col = 8'd5; in_row = 8'd6; in_colour = 3'b111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    k = 0;
    while (pq.size() < nb + 17 && k < 100) begin tick(); k++; end
    chk("blk_timeout", 32'(k < 100), 32'd1);
    bad = 0;
    for (int p = 0; p < 16; p++)
      if (pq.size() > nb + p)
        if (pq[nb + p] !== mk(20 + p % 4, 24 + p / 4, 7)) bad++;
    chk("blk_pixels", 32'(bad), 32'd0);
    if (pq.size() > nb + 16)
      chk("clr_first", 32'(pq[nb + 16]), 32'(mk(0, 0, 0)));

    // Nine events while the clear runs: only eight fit.
    for (int i = 0; i < 8; i++) begin
      in_col = 8'(ec[i]); in_row = 8'(er[i]);
      in_colour = (i % 2 == 1) ? 3'b000 : 3'b111;
      in_valid = 1'b1;
      chk("q_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_col = 8'(ec[8]); in_row = 8'(er[8]); in_colour = 3'b111;
    chk("q_full", 32'(in_ready), 32'd0);
    k = 0;
    while (!in_ready && k < 25000) begin tick(); k++; end
    chk("q9_timeout", 32'(k < 25000), 32'd1);
    chk("clr_count", 32'(pq.size() - (nb + 16)), 32'd19200);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (busy && k < 3000) begin tick(); k++; end
    chk("q_drain_timeout", 32'(k < 3000), 32'd1);
    repeat (2) tick();

    bad = 0;
    for (int p = 0; p < 19200; p++)
      if (pq.size() > nb + 16 + p)
        if (pq[nb + 16 + p] !== mk(p % 160, p / 160, 0)) bad++;
    chk("clr_pixels", 32'(bad), 32'd0);

    idx = nb + 16 + 19200;
    chk("q_plots", 32'(pq.size() - idx), 32'd144);
    bad = 0;
    for (int i = 0; i < 9; i++)
      for (int p = 0; p < 16; p++) begin
        exc = (i % 2 == 1) ? 0 : 7;
        if (pq.size() > idx + i * 16 + p)
          if (pq[idx + i * 16 + p] !==
              mk(ec[i] * 4 + p % 4, er[i] * 4 + p / 4, exc)) bad++;
      end
    chk("q_pixels", 32'(bad), 32'd0);
    if (pq.size() > 0)
      chk("corner_last", 32'(pq[pq.size() - 1]), 32'(mk(159, 119, 7)));

    // Reset partway through a clear discards everything.
    nc = pq.size();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_col = 8'd1; in_row = 8'd1; in_colour = 3'b111; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("rc_full", 32'(in_ready), 32'd0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    k = 0;
    while (pq.size() - nc < 500 && k < 2000) begin tick(); k++; end
    chk("rc_timeout", 32'(k < 2000), 32'd1);
    chk("rc_plot_on", 32'(plot), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("rc_plot", 32'(plot), 32'd0);
    chk("rc_ready", 32'(in_ready), 32'd1);
    chk("rc_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    ns = pq.size();
    repeat (50) tick();
    chk("rc_no_plots", 32'(pq.size() - ns), 32'd0);
    chk("rc_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
